spi_reg_cmd_engine: RTL and testbench
=====================================

Name: spi_reg_cmd_engine

Overview:
- Byte-level command/register engine sitting directly downstream of the SPI byte slave in the i_sys_clk domain.
- Consumes received bytes (rx valid pulse + byte) and decodes a command byte followed by a burst of data bytes.
- Drives a simple register bus: write strobes, and read request/ack.
- Feeds read data and status back to the slave through its tx-load handshake (tx valid pulse + byte).

Parameters:
ADDR_W, 7, register address width; command byte carries the address in bits [ADDR_W-1:0], ADDR_W <= 7.
AUTO_INC, 1, 1 = address increments after every data byte in a burst; 0 = address fixed for the frame.
RD_TIMEOUT, 8, max i_sys_clk cycles to wait for i_bus_rd_ack before substituting 8'hFF (range 2..255).

Ports:
i_sys_clk  in  1  system clock; all logic on rising edge.
i_rst  in  1  asynchronous, active-high reset.
i_spi_cs_b  in  1  raw SPI chip select (active low, asynchronous); synchronised internally with 2 flops.
i_rx_data_valid  in  1  one-cycle pulse: i_rx_byte holds a new received byte.
i_rx_byte  in  8  received byte.
o_tx_data_valid  out  1  one-cycle pulse loading o_tx_byte into the slave's shifter.
o_tx_byte  out  8  byte to shift out on MISO.
o_bus_addr  out  ADDR_W  register address.
o_bus_wr_en  out  1  one-cycle write strobe.
o_bus_wr_data  out  8  write data, valid with o_bus_wr_en.
o_bus_rd_req  out  1  level; held until ack, timeout or abort.
i_bus_rd_data  in  8  read data, valid with i_bus_rd_ack.
i_bus_rd_ack  in  1  one-cycle read acknowledge.
o_frame_active  out  1  synchronised CS asserted.
o_err_ovf  out  1  sticky: read data was not ready before the next byte completed.
o_err_tmo  out  1  sticky: read timeout occurred.
i_err_clr  in  1  clears both sticky flags; set has priority when both occur in the same cycle.

Behaviour:
- Reset: state IDLE, all outputs 0, except o_tx_byte = status byte. Address and timeout counters are 0.
- Status byte: {4'hA, 2'b00, o_err_ovf, o_err_tmo}.
  - While in IDLE, o_tx_byte continuously tracks the status byte, so the slave clocks status out during the command byte.
- cs_s is the synchronised CS. cs_s high forces state IDLE from any state:
  - o_bus_rd_req drops in the same cycle; a later ack is ignored.
  - No o_bus_wr_en is issued after CS deasserts.
- States:
  - IDLE: cs_s low and rx valid -> latch command. addr <= byte[ADDR_W-1:0].
    - byte[7] = 1 (write): go to WR.
    - byte[7] = 0 (read): go to RD_REQ.
  - WR: each rx valid in cycle N -> o_bus_wr_en = 1 in cycle N+1 with o_bus_wr_data = byte, o_bus_addr = current addr.
    - addr <= addr + AUTO_INC, visible in cycle N+2.
  - RD_REQ: o_bus_rd_req = 1 from the cycle after entry; the timeout counter runs.
    - ack in cycle N with no rx valid -> o_tx_byte = i_bus_rd_data and o_tx_data_valid pulse in cycle N+1; request drops in N+1; go to RD_HOLD.
    - Counter reaching RD_TIMEOUT without ack -> o_tx_byte = 8'hFF, tx pulse, o_err_tmo set, go to RD_HOLD.
    - rx valid while in RD_REQ (including the cycle the ack arrives) -> o_err_ovf set, data discarded, no tx pulse; addr advances and a fresh request issues (remain in RD_REQ, counter restarts).
  - RD_HOLD: wait for rx valid (the byte carrying the read data out; MOSI content ignored) -> addr advances, go to RD_REQ.
- Address arithmetic is modulo 2^ADDR_W (wrap 0x7F -> 0x00 for ADDR_W = 7).
- Read latency: command rx valid in cycle N -> o_bus_rd_req high in cycle N+1.
- Reset mid-frame: immediate, asynchronous return to reset values. The flags clear.

Test Plan:
- Write burst: CS low, bytes 0x85, 0x11, 0x22 -> wr_en pulses with addr 0x05/data 0x11, then addr 0x06/data 0x22; no tx pulse.
- Read burst: CS low, cmd 0x10; bus acks 3 cycles after each req with data 0xA0+addr -> tx pulses 0xB0, then 0xB1 after the next rx byte; addr 0x10 then 0x11.
- Timeout: cmd 0x03, no ack -> after RD_TIMEOUT (8) cycles, tx pulse 0xFF; o_err_tmo = 1; the next status byte read is 0xA1.
- Overrun/simultaneous: cmd 0x20; ack and the next rx valid arrive in the same cycle -> no tx pulse, o_err_ovf = 1, new req at addr 0x21; i_err_clr -> flags 0.
- Wrap and abort: write cmd 0xFF (addr 0x7F), two data bytes -> addresses 0x7F then 0x00. Then a read cmd followed by CS high while the req is pending -> req drops within 3 cycles; a later ack produces no tx pulse.
- Async reset asserted mid-burst -> all outputs reset immediately, o_tx_byte = 0xA0.

Source files
------------

// File: rtl/spi_reg_cmd_engine.sv
// Byte-level command/register engine behind an SPI byte slave: decodes a command byte,
// then runs write or read bursts on a simple register bus and returns data via tx-load.
module spi_reg_cmd_engine #(
    parameter int ADDR_W     = 7,
    parameter int AUTO_INC   = 1,
    parameter int RD_TIMEOUT = 8
) (
    input  logic              i_sys_clk,
    input  logic              i_rst,
    input  logic              i_spi_cs_b,
    input  logic              i_rx_data_valid,
    input  logic [7:0]        i_rx_byte,
    output logic              o_tx_data_valid,
    output logic [7:0]        o_tx_byte,
    output logic [ADDR_W-1:0] o_bus_addr,
    output logic              o_bus_wr_en,
    output logic [7:0]        o_bus_wr_data,
    output logic              o_bus_rd_req,
    input  logic [7:0]        i_bus_rd_data,
    input  logic              i_bus_rd_ack,
    output logic              o_frame_active,
    output logic              o_err_ovf,
    output logic              o_err_tmo,
    input  logic              i_err_clr
);

    typedef enum logic [1:0] {IDLE, WR, RD_REQ, RD_HOLD} state_t;

    localparam logic [ADDR_W-1:0] ADDR_STEP = (AUTO_INC != 0) ? ADDR_W'(1) : '0;
    localparam logic [7:0]        TMO_LAST  = 8'(RD_TIMEOUT - 1);

    function automatic logic [7:0] status_byte(input logic ovf, input logic tmo);
        return {4'hA, 2'b00, ovf, tmo};
    endfunction

    state_t            state, state_nxt;
    logic              cs_sync_p0, cs_s;
    logic              in_frame;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        tmo_cnt;
    logic              wr_en_q;
    logic [7:0]        wr_data_q;
    logic              tx_vld_q;
    logic [7:0]        tx_q;
    logic              err_ovf_q, err_tmo_q;
    logic              rd_ack_ok, rd_tmo, rd_ovf, hold_adv, cmd_take;

    // Chip-select synchroniser; reset value is "deselected".
    always_ff @(posedge i_sys_clk or posedge i_rst) begin
        if (i_rst) begin
            cs_sync_p0 <= 1'b1;
            cs_s       <= 1'b1;
        end else begin
            cs_sync_p0 <= i_spi_cs_b;
            cs_s       <= cs_sync_p0;
        end
    end

    assign in_frame  = ~cs_s;
    assign cmd_take  = (state == IDLE) & in_frame & i_rx_data_valid;
    assign rd_ovf    = (state == RD_REQ) & in_frame & i_rx_data_valid;
    assign rd_ack_ok = (state == RD_REQ) & in_frame & ~i_rx_data_valid & i_bus_rd_ack;
    assign rd_tmo    = (state == RD_REQ) & in_frame & ~i_rx_data_valid & ~i_bus_rd_ack
                       & (tmo_cnt == TMO_LAST);
    assign hold_adv  = (state == RD_HOLD) & in_frame & i_rx_data_valid;

    always_ff @(posedge i_sys_clk or posedge i_rst) begin
        if (i_rst) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (cs_s) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (i_rx_data_valid) state_nxt = i_rx_byte[7] ? WR : RD_REQ;
                WR:      state_nxt = WR;
                RD_REQ:  if (rd_ack_ok || rd_tmo) state_nxt = RD_HOLD;
                RD_HOLD: if (i_rx_data_valid) state_nxt = RD_REQ;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Outputs; the request and strobes are cut the moment the frame ends.
    always_comb begin
        o_frame_active  = in_frame;
        o_bus_rd_req    = (state == RD_REQ) & in_frame;
        o_bus_wr_en     = wr_en_q & in_frame;
        o_bus_wr_data   = wr_data_q;
        o_bus_addr      = addr;
        o_tx_data_valid = tx_vld_q & in_frame;
        o_tx_byte       = (state == IDLE) ? status_byte(err_ovf_q, err_tmo_q) : tx_q;
        o_err_ovf       = err_ovf_q;
        o_err_tmo       = err_tmo_q;
    end

    // Datapath: address, write pipe, read return, timeout counter, sticky flags.
    always_ff @(posedge i_sys_clk or posedge i_rst) begin
        if (i_rst) begin
            addr      <= '0;
            tmo_cnt   <= '0;
            wr_en_q   <= 1'b0;
            wr_data_q <= '0;
            tx_vld_q  <= 1'b0;
            tx_q      <= '0;
            err_ovf_q <= 1'b0;
            err_tmo_q <= 1'b0;
        end else begin
            if (cmd_take)
                addr <= i_rx_byte[ADDR_W-1:0];
            else if (wr_en_q || rd_ovf || hold_adv)
                addr <= addr + ADDR_STEP;

            if (state != RD_REQ || rd_ovf)
                tmo_cnt <= '0;
            else if (tmo_cnt != 8'hFF)
                tmo_cnt <= tmo_cnt + 8'd1;

            wr_en_q <= (state == WR) & in_frame & i_rx_data_valid;
            if ((state == WR) && in_frame && i_rx_data_valid)
                wr_data_q <= i_rx_byte;

            tx_vld_q <= rd_ack_ok | rd_tmo;
            if (state == IDLE)
                tx_q <= status_byte(err_ovf_q, err_tmo_q);
            else if (rd_ack_ok)
                tx_q <= i_bus_rd_data;
            else if (rd_tmo)
                tx_q <= 8'hFF;

            err_ovf_q <= (err_ovf_q & ~i_err_clr) | rd_ovf;
            err_tmo_q <= (err_tmo_q & ~i_err_clr) | rd_tmo;
        end
    end

endmodule

// File: tb/tb_spi_reg_cmd_engine.sv
// Directed bench for spi_reg_cmd_engine: a cycle table for write/read bursts plus
// hand sequences for timeout, overrun, wrap, abort and async reset.
module tb_spi_reg_cmd_engine;

    logic       clk = 1'b0;
    logic       rst, cs_b, rx_v, ack, err_clr;
    logic [7:0] rx_byte, rd_data;
    logic       tx_v, wr_en, rd_req, fa, ovf, tmo;
    logic [7:0] tx_byte, wr_data;
    logic [6:0] addr;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    spi_reg_cmd_engine #(.ADDR_W(7), .AUTO_INC(1), .RD_TIMEOUT(8)) dut (
        .i_sys_clk(clk), .i_rst(rst), .i_spi_cs_b(cs_b),
        .i_rx_data_valid(rx_v), .i_rx_byte(rx_byte),
        .o_tx_data_valid(tx_v), .o_tx_byte(tx_byte),
        .o_bus_addr(addr), .o_bus_wr_en(wr_en), .o_bus_wr_data(wr_data),
        .o_bus_rd_req(rd_req), .i_bus_rd_data(rd_data), .i_bus_rd_ack(ack),
        .o_frame_active(fa), .o_err_ovf(ovf), .o_err_tmo(tmo), .i_err_clr(err_clr)
    );

    typedef struct {
        logic        cs_b;
        logic        rx_v;
        logic [7:0]  rx_byte;
        logic        ack;
        logic [7:0]  rd_data;
        logic [28:0] exp;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic c, input logic rv, input logic [7:0] rb,
                                input logic ak, input logic [7:0] rd,
                                input logic w, input logic [7:0] wd, input logic [6:0] ad,
                                input logic rq, input logic tv, input logic [7:0] tb,
                                input logic f);
        vec_t v;
        v.cs_b = c; v.rx_v = rv; v.rx_byte = rb; v.ack = ak; v.rd_data = rd;
        v.exp = {w, wd, ad, rq, tv, tb, f, 1'b0, 1'b0};
        return v;
    endfunction

    function automatic logic [28:0] outs();
        return {wr_en, wr_data, addr, rd_req, tx_v, tx_byte, fa, ovf, tmo};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
        else n_pass++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        rx_v = 0; rx_byte = 8'h00; ack = 0; rd_data = 8'h00; err_clr = 0;
    endtask

    task automatic open_frame();
        cs_b = 0;
        tick();
        tick();
    endtask

    task automatic rx(input logic [7:0] b);
        rx_v = 1; rx_byte = b;
        tick();
        rx_v = 0;
    endtask

    initial begin
        rst = 1; cs_b = 1; idle_in();

        // Write burst then read burst, one row per clock.
        vecs.push_back(mk(0,0,8'h00,0,8'h00, 0,8'h00,7'h00,0,0,8'hA0,0));
        vecs.push_back(mk(0,0,8'h00,0,8'h00, 0,8'h00,7'h00,0,0,8'hA0,1));
        vecs.push_back(mk(0,1,8'h85,0,8'h00, 0,8'h00,7'h05,0,0,8'hA0,1));
        vecs.push_back(mk(0,1,8'h11,0,8'h00, 1,8'h11,7'h05,0,0,8'hA0,1));
        vecs.push_back(mk(0,0,8'h00,0,8'h00, 0,8'h11,7'h06,0,0,8'hA0,1));
        vecs.push_back(mk(0,1,8'h22,0,8'h00, 1,8'h22,7'h06,0,0,8'hA0,1));
        vecs.push_back(mk(0,0,8'h00,0,8'h00, 0,8'h22,7'h07,0,0,8'hA0,1));
        vecs.push_back(mk(1,0,8'h00,0,8'h00, 0,8'h22,7'h07,0,0,8'hA0,1));
        vecs.push_back(mk(1,0,8'h00,0,8'h00, 0,8'h22,7'h07,0,0,8'hA0,0));
        vecs.push_back(mk(1,0,8'h00,0,8'h00, 0,8'h22,7'h07,0,0,8'hA0,0));
        vecs.push_back(mk(0,0,8'h00,0,8'h00, 0,8'h22,7'h07,0,0,8'hA0,0));
        vecs.push_back(mk(0,0,8'h00,0,8'h00, 0,8'h22,7'h07,0,0,8'hA0,1));
        vecs.push_back(mk(0,1,8'h10,0,8'h00, 0,8'h22,7'h10,1,0,8'hA0,1));
        vecs.push_back(mk(0,0,8'h00,0,8'h00, 0,8'h22,7'h10,1,0,8'hA0,1));
        vecs.push_back(mk(0,0,8'h00,0,8'h00, 0,8'h22,7'h10,1,0,8'hA0,1));
        vecs.push_back(mk(0,0,8'h00,0,8'h00, 0,8'h22,7'h10,1,0,8'hA0,1));
        vecs.push_back(mk(0,0,8'h00,1,8'hB0, 0,8'h22,7'h10,0,1,8'hB0,1));
        vecs.push_back(mk(0,0,8'h00,0,8'h00, 0,8'h22,7'h10,0,0,8'hB0,1));
        vecs.push_back(mk(0,1,8'h00,0,8'h00, 0,8'h22,7'h11,1,0,8'hB0,1));
        vecs.push_back(mk(0,0,8'h00,0,8'h00, 0,8'h22,7'h11,1,0,8'hB0,1));
        vecs.push_back(mk(0,0,8'h00,0,8'h00, 0,8'h22,7'h11,1,0,8'hB0,1));
        vecs.push_back(mk(0,0,8'h00,0,8'h00, 0,8'h22,7'h11,1,0,8'hB0,1));
        vecs.push_back(mk(0,0,8'h00,1,8'hB1, 0,8'h22,7'h11,0,1,8'hB1,1));
        vecs.push_back(mk(0,0,8'h00,0,8'h00, 0,8'h22,7'h11,0,0,8'hB1,1));
        vecs.push_back(mk(1,0,8'h00,0,8'h00, 0,8'h22,7'h11,0,0,8'hB1,1));
        vecs.push_back(mk(1,0,8'h00,0,8'h00, 0,8'h22,7'h11,0,0,8'hB1,0));
        vecs.push_back(mk(1,0,8'h00,0,8'h00, 0,8'h22,7'h11,0,0,8'hA0,0));

        // Reset state
        tick(); tick();
        chk("reset_state", {3'b0, outs()}, {3'b0, 1'b0,8'h00,7'h00,1'b0,1'b0,8'hA0,1'b0,1'b0,1'b0});
        rst = 0;
        tick();

        for (int i = 0; i < vecs.size(); i++) begin
            cs_b = vecs[i].cs_b; rx_v = vecs[i].rx_v; rx_byte = vecs[i].rx_byte;
            ack = vecs[i].ack; rd_data = vecs[i].rd_data;
            tick();
            chk($sformatf("row%0d", i), {3'b0, outs()}, {3'b0, vecs[i].exp});
        end
        idle_in();

        // Timeout: no ack for RD_TIMEOUT cycles
        open_frame();
        rx(8'h03);
        chk("tmo_addr", {25'b0, addr}, 32'h03);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("tmo_wait%0d", i), {30'b0, rd_req, tx_v}, 32'b10);
            tick();
        end
        chk("tmo_fire", {20'b0, tx_v, rd_req, tmo, ovf, tx_byte}, {20'b0, 4'b1010, 8'hFF});
        cs_b = 1;
        tick(); tick(); tick();
        chk("tmo_status", {24'b0, tx_byte}, 32'hA1);
        err_clr = 1;
        tick();
        err_clr = 0;
        chk("tmo_clear", {23'b0, tmo, tx_byte}, {23'b0, 1'b0, 8'hA0});

        // Overrun: ack and rx in the same cycle
        open_frame();
        rx(8'h20);
        chk("ovf_req", {24'b0, rd_req, addr}, {24'b0, 1'b1, 7'h20});
        tick();
        ack = 1; rd_data = 8'h55; rx_v = 1; rx_byte = 8'h00;
        tick();
        idle_in();
        chk("ovf_hit", {22'b0, tx_v, ovf, rd_req, addr}, {22'b0, 3'b011, 7'h21});
        tick();
        chk("ovf_no_tx", {30'b0, tx_v, rd_req}, 32'b01);
        rx_v = 1; err_clr = 1;
        tick();
        idle_in();
        chk("ovf_set_prio", {24'b0, ovf, addr}, {24'b0, 1'b1, 7'h22});
        err_clr = 1;
        tick();
        err_clr = 0;
        chk("ovf_clear", {30'b0, ovf, rd_req}, 32'b01);

        // Abort with request pending, then a stale ack
        cs_b = 1;
        tick(); tick(); tick();
        chk("abort_req", {30'b0, rd_req, fa}, 32'b00);
        ack = 1; rd_data = 8'h77;
        tick();
        ack = 0;
        chk("abort_ack1", {23'b0, tx_v, tx_byte}, {23'b0, 1'b0, 8'hA0});
        tick();
        chk("abort_ack2", {31'b0, tx_v}, 32'b0);

        // Address wrap in a write burst, then no strobe after CS release
        open_frame();
        rx(8'hFF);
        rx(8'hAA);
        chk("wrap_7f", {16'b0, wr_en, addr, wr_data}, {16'b0, 1'b1, 7'h7F, 8'hAA});
        rx(8'hBB);
        chk("wrap_00", {16'b0, wr_en, addr, wr_data}, {16'b0, 1'b1, 7'h00, 8'hBB});
        tick();
        chk("wrap_01", {24'b0, wr_en, addr}, {24'b0, 1'b0, 7'h01});
        cs_b = 1;
        tick(); tick();
        rx(8'h33);
        chk("no_wr_after_cs", {24'b0, wr_en, addr}, {24'b0, 1'b0, 7'h01});
        tick();

        // Asynchronous reset mid read burst
        open_frame();
        rx(8'h10);
        rx(8'h00);
        chk("pre_rst", {29'b0, rd_req, ovf, fa}, 32'b111);
        #2 rst = 1;
        #1;
        chk("async_rst", {3'b0, outs()}, {3'b0, 1'b0,8'h00,7'h00,1'b0,1'b0,8'hA0,1'b0,1'b0,1'b0});
        tick();
        rst = 0;
        cs_b = 1;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
